// File: rtl/lp_pkg.sv
// Shared opcode definitions for the low-power issue queue and the control unit.
// Contents: opcode_t, the opcode constants, and a NOP test helper.
package lp_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OPCODE_NOP   = 4'h0;
    localparam opcode_t OPCODE_LOAD  = 4'h1;
    localparam opcode_t OPCODE_STORE = 4'h2;
    localparam opcode_t OPCODE_ADD   = 4'h3;
    localparam opcode_t OPCODE_SUB   = 4'h4;
    localparam opcode_t OPCODE_AND   = 4'h5;
    localparam opcode_t OPCODE_OR    = 4'h6;
    localparam opcode_t OPCODE_XOR   = 4'h7;
    localparam opcode_t OPCODE_SHL   = 4'h8;
    localparam opcode_t OPCODE_SHR   = 4'h9;
    localparam opcode_t OPCODE_CMP   = 4'hA;
    localparam opcode_t OPCODE_BEQ   = 4'hB;
    localparam opcode_t OPCODE_BNE   = 4'hC;
    localparam opcode_t OPCODE_JMP   = 4'hD;
    localparam opcode_t OPCODE_SLEEP = 4'hE;
    localparam opcode_t OPCODE_HALT  = 4'hF;

    function automatic logic is_nop(input opcode_t op);
        return op == OPCODE_NOP;
    endfunction

endpackage

// File: rtl/lp_fifo_core.sv
// Pointer-based FIFO storage with full/empty/occupancy.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers only)
//   clear         synchronous pointer reset (discards all entries)
//   push, wr_data write one entry at the tail (caller guarantees !full)
//   pop           advance the head (caller guarantees !empty)
//   head          current head entry (combinational read)
//   full, empty   occupancy flags
//   count         wr_ptr - rd_ptr
module lp_fifo_core #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign head  = mem_reg[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/low_power_issue_queue.sv
// Opcode issue queue in front of the low-power control unit.
// Buffers fetched opcodes and issues at most one per cycle through a registered
// opcode/valid pair. The opcode register only loads on an issue, so the
// decoder's gated registers see no toggling while the queue is quiet.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_opcode  fetch offer; in_ready says the offer is taken
//   stall, flush         downstream hazard hold / redirect discard
//   opcode, valid        registered issue to the control unit
//   count                FIFO occupancy
//   idle                 registered hint after IDLE_CYCLES quiet cycles
module low_power_issue_queue
    import lp_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int IDLE_CYCLES = 8,
    parameter bit DROP_NOP    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  opcode_t                in_opcode,
    output logic                   in_ready,
    input  logic                   stall,
    input  logic                   flush,
    output opcode_t                opcode,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    logic    full;
    logic    empty;
    opcode_t head;
    logic    accept;
    logic    push;
    logic    pop;

    logic [IW-1:0] idle_cnt_reg;
    logic [IW-1:0] idle_cnt_next;

    // A same-cycle pop never frees a slot for a push: in_ready looks at
    // current occupancy only, which keeps this path short.
    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;
    // A dropped NOP is still handshaken, it just never reaches storage.
    assign push     = accept && !(DROP_NOP && is_nop(in_opcode));
    assign pop      = !flush && !stall && !empty;

    lp_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(opcode_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push    (push),
        .wr_data (in_opcode),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // opcode loads only on an issue; flush and idle cycles just drop valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode <= OPCODE_NOP;
            valid  <= 1'b0;
        end else if (flush) begin
            valid  <= 1'b0;
        end else if (pop) begin
            opcode <= head;
            valid  <= 1'b1;
        end else begin
            valid  <= 1'b0;
        end
    end

    // Quiet-cycle counter: empty, nothing written, nothing issued last cycle.
    // Flush deliberately leaves it alone.
    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (push) begin
            idle_cnt_next = '0;
        end else if (empty && !valid && (idle_cnt_reg != IDLE_MAX)) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
            idle         <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            idle         <= (idle_cnt_next == IDLE_MAX);
        end
    end

endmodule

// File: tb/tb_low_power_issue_queue.sv
// Scoreboard bench for low_power_issue_queue. Two instances share stimulus:
// d0 keeps NOPs, d1 drops them. Each step applies inputs, checks in_ready,
// clocks once, updates the reference queues and compares all outputs.
module tb_low_power_issue_queue;
    import lp_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDLE  = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    in_valid = 1'b0;
    opcode_t in_opcode = OPCODE_NOP;
    logic    stall = 1'b0;
    logic    flush = 1'b0;

    logic [1:0]    rdy_w;
    logic [1:0]    vld_w;
    logic [1:0]    idle_w;
    opcode_t       op_w [2];
    logic [CW-1:0] cnt_w [2];

    always #5 clk = ~clk;

    low_power_issue_queue #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .DROP_NOP(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_ready(rdy_w[0]), .stall(stall), .flush(flush), .opcode(op_w[0]),
        .valid(vld_w[0]), .count(cnt_w[0]), .idle(idle_w[0])
    );

    low_power_issue_queue #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .DROP_NOP(1'b1)) dut_nop (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_ready(rdy_w[1]), .stall(stall), .flush(flush), .opcode(op_w[1]),
        .valid(vld_w[1]), .count(cnt_w[1]), .idle(idle_w[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance
    opcode_t q0[$];
    opcode_t q1[$];
    logic    m_vld [2];
    opcode_t m_op  [2];
    int      m_icnt [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_vld[d]  = 1'b0;
            m_op[d]   = OPCODE_NOP;
            m_icnt[d] = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s d%0d valid", ph, d), 32'(vld_w[d]), 32'(m_vld[d]));
            check_eq($sformatf("%s d%0d opcode", ph, d), 32'(op_w[d]), 32'(m_op[d]));
            check_eq($sformatf("%s d%0d count", ph, d), 32'(cnt_w[d]), 32'(qsize(d)));
            check_eq($sformatf("%s d%0d idle", ph, d), 32'(idle_w[d]), 32'(m_icnt[d] == IDLE));
        end
    endtask

    task automatic step(input logic v, input opcode_t op, input logic st, input logic fl);
        logic push_m [2];
        logic pop_m  [2];
        int   sz     [2];
        logic exp_rdy;
        in_valid  = v;
        in_opcode = op;
        stall     = st;
        flush     = fl;
        #1;
        for (int d = 0; d < 2; d++) begin
            sz[d]     = qsize(d);
            exp_rdy   = (sz[d] < DEPTH) && !fl;
            check_eq($sformatf("in_ready d%0d", d), 32'(rdy_w[d]), 32'(exp_rdy));
            push_m[d] = v && exp_rdy && !((d == 1) && (op == OPCODE_NOP));
            pop_m[d]  = !fl && !st && (sz[d] > 0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (push_m[d]) m_icnt[d] = 0;
            else if (sz[d] == 0 && !m_vld[d] && m_icnt[d] < IDLE) m_icnt[d]++;
            if (fl) begin
                if (d == 0) q0.delete(); else q1.delete();
                m_vld[d] = 1'b0;
            end else if (pop_m[d]) begin
                if (d == 0) m_op[d] = q0.pop_front(); else m_op[d] = q1.pop_front();
                m_vld[d] = 1'b1;
            end else begin
                m_vld[d] = 1'b0;
            end
            if (push_m[d]) begin
                if (d == 0) q0.push_back(op); else q1.push_back(op);
            end
        end
        $display("t=%0t in_v=%0b in_op=%0h stall=%0b flush=%0b | d0 v=%0b op=%0h cnt=%0d | d1 v=%0b op=%0h cnt=%0d",
                 $time, v, op, st, fl, vld_w[0], op_w[0], cnt_w[0], vld_w[1], op_w[1], cnt_w[1]);
        check_outputs("step");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        check_eq("reset in_ready d0", 32'(rdy_w[0]), 32'd1);
        rst = 1'b0;

        // Idle hint: empty from reset for IDLE edges
        repeat (IDLE) step(1'b0, OPCODE_NOP, 1'b0, 1'b0);
        check_eq("idle after 8 empty", 32'(idle_w[0]), 32'd1);

        // Back-to-back 1,2,3 then hold
        step(1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        repeat (2) step(1'b0, OPCODE_NOP, 1'b0, 1'b0);

        // Fill under stall, 5th offer refused, then drain with no gaps
        for (int i = 0; i < 5; i++) step(1'b1, opcode_t'(4 + i), 1'b1, 1'b0);
        repeat (2) step(1'b0, OPCODE_NOP, 1'b1, 1'b0);
        repeat (5) step(1'b0, OPCODE_NOP, 1'b0, 1'b0);

        // Steady push+pop across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, opcode_t'(i + 1), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, opcode_t'(i + 3), 1'b0, 1'b0);
        repeat (4) step(1'b0, OPCODE_NOP, 1'b0, 1'b0);

        // Flush with three queued and an offer present
        step(1'b1, 4'hA, 1'b1, 1'b0);
        step(1'b1, 4'hB, 1'b1, 1'b0);
        step(1'b1, 4'hC, 1'b1, 1'b0);
        step(1'b1, 4'hE, 1'b0, 1'b1);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b0, OPCODE_NOP, 1'b0, 1'b0);
        check_eq("post-flush opcode d0", 32'(op_w[0]), 32'h9);

        // NOP drop: d1 only issues 6 and 7
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b0);
        repeat (3) step(1'b0, OPCODE_NOP, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst
        step(1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_eq("async_rst in_ready d0", 32'(rdy_w[0]), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 4'h5, 1'b0, 1'b0);
        step(1'b0, OPCODE_NOP, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
